// File: rtl/spi_sclk_frame_gen.sv
// SPI master serial-clock generator: prescaled SCLK bursts of a programmable
// number of cycles, with shift/sample strobes, busy/done/abort handshake and wait-mode freeze.
module spi_sclk_frame_gen #(
    parameter int SPPR_W  = 3,
    parameter int SPR_W   = 3,
    parameter int DIV_W   = 12,
    parameter int FRAME_W = 4
) (
    input  logic               PCLK,
    input  logic               PRESET_n,
    input  logic               enable_i,
    input  logic [1:0]         spi_mode_i,
    input  logic               spiswai_i,
    input  logic               ss_i,
    input  logic [SPPR_W-1:0]  sppr_i,
    input  logic [SPR_W-1:0]   spr_i,
    input  logic               cpol_i,
    input  logic               cpha_i,
    input  logic [FRAME_W-1:0] frame_len_i,
    input  logic               start_i,
    output logic               sclk_o,
    output logic               shift_o,
    output logic               sample_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               abort_o,
    output logic [FRAME_W-1:0] bit_cnt_o,
    output logic [DIV_W-1:0]   BaudRateDivisor_o
);

    if (DIV_W < SPPR_W + 2**SPR_W + 1) begin : g_div_w_check
        $error("spi_sclk_frame_gen: DIV_W too small for the largest divisor");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [DIV_W-1:0]   cnt_r, cnt_nxt_s;
    logic [FRAME_W:0]   edge_r, edge_nxt_s;
    logic [FRAME_W-1:0] bit_r, bit_nxt_s;
    logic               sclk_r, sclk_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               abort_r, abort_nxt_s;
    logic [SPPR_W-1:0]  sppr_l_r, sppr_l_nxt_s;
    logic [SPR_W-1:0]   spr_l_r, spr_l_nxt_s;
    logic               cpol_l_r, cpol_l_nxt_s;
    logic               cpha_l_r, cpha_l_nxt_s;
    logic [FRAME_W-1:0] fl_l_r, fl_l_nxt_s;
    logic [DIV_W-1:0]   div_r;

    logic [DIV_W-1:0]   half_m1_s;
    logic [SPR_W:0]     spr_p1_s;
    logic               frozen_s;
    logic               abort_req_s;
    logic               tick_s;
    logic               last_s;
    logic               strobe_s;
    logic               lead_s;
    logic               start_ok_s;

    // Half-period uses only the configuration captured when the frame started.
    assign half_m1_s   = ((DIV_W'(sppr_l_r) + DIV_W'(1)) << spr_l_r) - DIV_W'(1);
    assign spr_p1_s    = {1'b0, spr_i} + (SPR_W+1)'(1);
    assign frozen_s    = (spi_mode_i == 2'b01) && spiswai_i;
    assign abort_req_s = ss_i || !enable_i;
    assign tick_s      = (cnt_r == half_m1_s);
    // Edge index 2*frame_len+1 is the final trailing edge of the frame.
    assign last_s      = (edge_r == {fl_l_r, 1'b1});
    assign lead_s      = ~edge_r[0];
    assign strobe_s    = (state_r == ST_RUN) && !frozen_s && tick_s;
    assign start_ok_s  = start_i && enable_i && !ss_i;

    assign shift_o           = strobe_s && (lead_s ? cpha_l_r : !cpha_l_r);
    assign sample_o          = strobe_s && (lead_s ? !cpha_l_r : cpha_l_r);
    assign sclk_o            = sclk_r;
    assign busy_o            = busy_r;
    assign frame_done_o      = done_r;
    assign abort_o           = abort_r;
    assign bit_cnt_o         = bit_r;
    assign BaudRateDivisor_o = div_r;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        edge_nxt_s   = edge_r;
        bit_nxt_s    = bit_r;
        sclk_nxt_s   = sclk_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        abort_nxt_s  = 1'b0;
        sppr_l_nxt_s = sppr_l_r;
        spr_l_nxt_s  = spr_l_r;
        cpol_l_nxt_s = cpol_l_r;
        cpha_l_nxt_s = cpha_l_r;
        fl_l_nxt_s   = fl_l_r;
        case (state_r)
            ST_IDLE: begin
                sclk_nxt_s = cpol_i;
                cnt_nxt_s  = '0;
                edge_nxt_s = '0;
                bit_nxt_s  = '0;
                busy_nxt_s = 1'b0;
                if (start_ok_s) begin
                    state_nxt_s  = ST_RUN;
                    busy_nxt_s   = 1'b1;
                    sppr_l_nxt_s = sppr_i;
                    spr_l_nxt_s  = spr_i;
                    cpol_l_nxt_s = cpol_i;
                    cpha_l_nxt_s = cpha_i;
                    fl_l_nxt_s   = frame_len_i;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_req_s) begin
                    state_nxt_s = ST_IDLE;
                    sclk_nxt_s  = cpol_l_r;
                    cnt_nxt_s   = '0;
                    edge_nxt_s  = '0;
                    bit_nxt_s   = '0;
                    busy_nxt_s  = 1'b0;
                    abort_nxt_s = 1'b1;
                end else if (frozen_s) begin
                    state_nxt_s = ST_RUN;
                end else if (tick_s) begin
                    cnt_nxt_s = '0;
                    if (last_s) begin
                        state_nxt_s = ST_IDLE;
                        sclk_nxt_s  = cpol_l_r;
                        edge_nxt_s  = '0;
                        bit_nxt_s   = '0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        sclk_nxt_s = ~sclk_r;
                        edge_nxt_s = edge_r + (FRAME_W+1)'(1);
                        if (edge_r[0]) begin
                            bit_nxt_s = bit_r + FRAME_W'(1);
                        end else begin
                            bit_nxt_s = bit_r;
                        end
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sclk_nxt_s  = cpol_i;
                cnt_nxt_s   = '0;
                edge_nxt_s  = '0;
                bit_nxt_s   = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            edge_r   <= '0;
            bit_r    <= '0;
            sclk_r   <= cpol_i;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            abort_r  <= 1'b0;
            sppr_l_r <= '0;
            spr_l_r  <= '0;
            cpol_l_r <= 1'b0;
            cpha_l_r <= 1'b0;
            fl_l_r   <= '0;
            div_r    <= '0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            edge_r   <= edge_nxt_s;
            bit_r    <= bit_nxt_s;
            sclk_r   <= sclk_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            abort_r  <= abort_nxt_s;
            sppr_l_r <= sppr_l_nxt_s;
            spr_l_r  <= spr_l_nxt_s;
            cpol_l_r <= cpol_l_nxt_s;
            cpha_l_r <= cpha_l_nxt_s;
            fl_l_r   <= fl_l_nxt_s;
            div_r    <= (DIV_W'(sppr_i) + DIV_W'(1)) << spr_p1_s;
        end
    end

endmodule

// File: tb/tb_spi_sclk_frame_gen.sv
// Self-checking bench for spi_sclk_frame_gen: a cycle-count model of each frame
// is compared against the DUT every cycle, plus directed literal timing checks.
module tb_spi_sclk_frame_gen;

    logic       PCLK = 1'b0;
    logic       PRESET_n;
    logic       enable_i;
    logic [1:0] spi_mode_i;
    logic       spiswai_i;
    logic       ss_i;
    logic [2:0] sppr_i;
    logic [2:0] spr_i;
    logic       cpol_i;
    logic       cpha_i;
    logic [3:0] frame_len_i;
    logic       start_i;
    logic       sclk_o, shift_o, sample_o, busy_o, frame_done_o, abort_o;
    logic [3:0] bit_cnt_o;
    logic [11:0] BaudRateDivisor_o;

    spi_sclk_frame_gen dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .enable_i(enable_i), .spi_mode_i(spi_mode_i),
        .spiswai_i(spiswai_i), .ss_i(ss_i), .sppr_i(sppr_i), .spr_i(spr_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .frame_len_i(frame_len_i), .start_i(start_i),
        .sclk_o(sclk_o), .shift_o(shift_o), .sample_o(sample_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .abort_o(abort_o), .bit_cnt_o(bit_cnt_o),
        .BaudRateDivisor_o(BaudRateDivisor_o)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: a frame is described by its elapsed unfrozen cycle count e.
    bit m_valid = 1'b0;
    bit m_active = 1'b0;
    int m_e = 0;
    int m_half = 1;
    int m_fl = 0;
    bit m_cpol = 1'b0;
    bit m_cpha = 1'b0;
    bit ex_sclk, ex_busy, ex_done, ex_abort;
    int ex_bit, ex_div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        int n;
        if (!PRESET_n) begin
            m_active = 1'b0; m_e = 0; ex_sclk = cpol_i; ex_busy = 1'b0;
            ex_done = 1'b0; ex_abort = 1'b0; ex_bit = 0; ex_div = 0; m_valid = 1'b1;
        end else begin
            ex_div = (int'(sppr_i) + 1) << (int'(spr_i) + 1);
            ex_done = 1'b0;
            ex_abort = 1'b0;
            if (m_active) begin
                if (ss_i || !enable_i) begin
                    m_active = 1'b0; ex_abort = 1'b1; ex_sclk = m_cpol;
                end else if (!(spi_mode_i == 2'b01 && spiswai_i)) begin
                    m_e++;
                    if (m_e / m_half == 2 * (m_fl + 1)) begin
                        m_active = 1'b0; ex_done = 1'b1; ex_sclk = m_cpol;
                    end
                end
            end else begin
                ex_sclk = cpol_i;
                if (start_i && enable_i && !ss_i) begin
                    m_active = 1'b1; m_e = 0; m_cpol = cpol_i; m_cpha = cpha_i;
                    m_half = (int'(sppr_i) + 1) << int'(spr_i); m_fl = int'(frame_len_i);
                end
            end
            n = m_e / m_half;
            if (m_active) begin
                ex_sclk = m_cpol ^ n[0];
                ex_bit = n / 2;
            end else begin
                ex_bit = 0;
            end
            ex_busy = m_active;
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        model_update();
        cyc++;
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge PCLK) begin
        bit tk, lead, fz;
        if (m_valid) begin
            fz   = (spi_mode_i == 2'b01) && spiswai_i;
            tk   = m_active && !fz && (((m_e + 1) % m_half) == 0);
            lead = ((m_e / m_half) % 2) == 0;
            chk("sclk", sclk_o, ex_sclk);
            chk("busy", busy_o, ex_busy);
            chk("done", frame_done_o, ex_done);
            chk("abort", abort_o, ex_abort);
            chk("bit_cnt", bit_cnt_o, ex_bit);
            chk("divisor", BaudRateDivisor_o, ex_div);
            chk("shift", shift_o, tk && (lead ? m_cpha : !m_cpha));
            chk("sample", sample_o, tk && (lead ? !m_cpha : m_cpha));
        end
    end

    task automatic start_frame(input int sp, input int sr, input bit pol, input bit pha,
                               input int fl, output int k);
        sppr_i = sp[2:0]; spr_i = sr[2:0]; cpol_i = pol; cpha_i = pha; frame_len_i = fl[3:0];
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int budget, input bit pol, output int at, output int nsh,
                             output int nsa, output int rise);
        at = -1; nsh = 0; nsa = 0; rise = -1;
        for (int i = 0; i < budget; i++) begin
            if (shift_o === 1'b1) nsh++;
            if (sample_o === 1'b1) nsa++;
            step();
            if (rise < 0 && sclk_o !== pol) rise = cyc;
            if (frame_done_o === 1'b1) begin
                at = cyc;
                break;
            end
            if (busy_o !== 1'b1) break;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, at, nsh, nsa, rise;
        bit frz;
        PRESET_n = 1'b0; enable_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0; ss_i = 1'b0;
        sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0; frame_len_i = 4'd0;
        start_i = 1'b0;
        step(); step();
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_div", BaudRateDivisor_o, 12'd0);
        PRESET_n = 1'b1;
        step();

        // Basic frame: HALF=2, 8 bits, mode 0.
        start_frame(0, 1, 1'b0, 1'b0, 7, k);
        chk("basic_busy_at_k", busy_o, 1'b1);
        chk("basic_div", BaudRateDivisor_o, 12'd4);
        wait_done(100, 1'b0, at, nsh, nsa, rise);
        chk("basic_done_time", at - k, 32);
        chk("basic_first_rise", rise - k, 2);
        chk("basic_samples", nsa, 8);
        chk("basic_shifts", nsh, 8);
        chk("basic_busy_low", busy_o, 1'b0);
        step();

        // All CPOL/CPHA combinations with HALF=1.
        for (int c = 0; c < 4; c++) begin
            bit pol, pha;
            pol = c[1]; pha = c[0];
            cpol_i = pol;
            step(); step();
            chk("combo_idle", sclk_o, pol);
            start_frame(0, 0, pol, pha, 3, k);
            chk("combo_first_shift", shift_o, pha);
            chk("combo_first_sample", sample_o, !pha);
            wait_done(50, pol, at, nsh, nsa, rise);
            chk("combo_done_time", at - k, 8);
            chk("combo_strobes", nsh + nsa, 8);
            step();
        end

        // Maximum divisor.
        start_frame(7, 7, 1'b0, 1'b0, 0, k);
        chk("max_div", BaudRateDivisor_o, 12'd2048);
        wait_done(3000, 1'b0, at, nsh, nsa, rise);
        chk("max_first_edge", rise - k, 1024);
        chk("max_done_time", at - k, 2048);
        step();

        // Freeze for 10 cycles after the 3rd edge.
        start_frame(0, 1, 1'b0, 1'b0, 3, k);
        while (cyc < k + 6) step();
        spi_mode_i = 2'b01; spiswai_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("freeze_sclk", sclk_o, 1'b1);
            chk("freeze_bit", bit_cnt_o, 4'd1);
        end
        spi_mode_i = 2'b00; spiswai_i = 1'b0;
        wait_done(100, 1'b0, at, nsh, nsa, rise);
        chk("freeze_done_time", at - k, 26);
        step();

        // Abort by raising ss after the 5th edge.
        start_frame(0, 1, 1'b1, 1'b0, 7, k);
        while (cyc < k + 10) step();
        ss_i = 1'b1;
        step();
        chk("abort_pulse", abort_o, 1'b1);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_sclk", sclk_o, 1'b1);
        chk("abort_no_done", frame_done_o, 1'b0);
        ss_i = 1'b0;
        step();
        start_frame(0, 0, 1'b1, 1'b1, 1, k);
        wait_done(50, 1'b1, at, nsh, nsa, rise);
        chk("after_abort_done", at - k, 4);
        step();

        // Reset mid-frame.
        start_frame(0, 1, 1'b1, 1'b0, 7, k);
        step(); step(); step(); step(); step();
        PRESET_n = 1'b0;
        step();
        chk("rst_sclk", sclk_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_bit", bit_cnt_o, 4'd0);
        chk("rst_div", BaudRateDivisor_o, 12'd0);
        chk("rst_done", frame_done_o, 1'b0);
        chk("rst_abort", abort_o, 1'b0);
        PRESET_n = 1'b1;
        step(); step();

        // Mid-frame config change does not alter timing.
        start_frame(0, 1, 1'b0, 1'b0, 3, k);
        step(); step(); step();
        spr_i = 3'd3; sppr_i = 3'd5; cpha_i = 1'b1; frame_len_i = 4'd9;
        wait_done(200, 1'b0, at, nsh, nsa, rise);
        chk("cfg_change_done", at - k, 16);
        step();

        // Randomized frames with freezes, aborts, stray starts and config churn.
        frz = 1'b0;
        for (int f = 0; f < 40; f++) begin
            sppr_i = 3'($urandom_range(0, 3)); spr_i = 3'($urandom_range(0, 2));
            cpol_i = 1'($urandom_range(0, 1)); cpha_i = 1'($urandom_range(0, 1));
            frame_len_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                ss_i = 1'b1; start_i = 1'b1; step();
                ss_i = 1'b0; enable_i = 1'b0; step();
                enable_i = 1'b1; start_i = 1'b0;
            end
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            for (int c = 0; c < 4000 && busy_o === 1'b1; c++) begin
                if (frz) frz = ($urandom_range(0, 3) != 0);
                else     frz = ($urandom_range(0, 29) == 0);
                if (frz) begin
                    spi_mode_i = 2'b01; spiswai_i = 1'b1;
                end else begin
                    spi_mode_i = 2'($urandom_range(0, 3));
                    spiswai_i = (spi_mode_i == 2'b01) ? 1'b0 : 1'($urandom_range(0, 1));
                end
                ss_i = ($urandom_range(0, 299) == 0);
                enable_i = ($urandom_range(0, 299) != 0);
                start_i = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    sppr_i = 3'($urandom_range(0, 7)); spr_i = 3'($urandom_range(0, 7));
                    cpol_i = 1'($urandom_range(0, 1)); frame_len_i = 4'($urandom_range(0, 15));
                end
                step();
            end
            chk("rand_frame_ends", busy_o, 1'b0);
            start_i = 1'b0; ss_i = 1'b0; enable_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0;
            frz = 1'b0;
            step(); step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
